bit_scanner: RTL and testbench
==============================

Name: bit_scanner

Overview:
- Sequential decoder of a mask byte: given an 8-bit mask, emits the index of each selected bit, one per handshake, then reports the total count.
- Acts as the inverse of the datapath's AND/OR/XOR mask logic: it turns a mask back into bit positions.
- Serves bit-iterate micro-ops and the interrupt-pending scan in the ez8 core.
- Handles one job at a time, examining one bit per clock.

Parameters:
- WIDTH, 8, width of the scanned value. IW = $clog2(WIDTH) is a derived localparam, not overridable.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request a scan; sampled only in IDLE
- value  in  WIDTH  mask to scan; captured when start is accepted
- msb_first  in  1  scan order: 0 = bit 0 upward, 1 = bit WIDTH-1 downward; captured with value
- match_zero  in  1  0 = report set bits, 1 = report clear bits; captured with value
- idx_valid  out  1  idx holds a matching bit position
- idx  out  IW  position of the current match
- idx_ready  in  1  consumer accepts idx this cycle
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- done  out  1  one-cycle pulse when the scan completes
- count  out  IW+1  number of matches in the last scan; valid from done, held until the next accepted start

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset).
- Reset values: state IDLE; idx_valid, idx, busy, done, count all 0. Reset mid-scan aborts immediately and the pending idx is dropped.
- States: IDLE, SCAN, EMIT, DONE. All outputs are registered.
- IDLE:
  - start=1 latches value, msb_first and match_zero.
  - Sets ptr to the first position (0, or WIDTH-1 when msb_first), clears count, goes to SCAN.
  - start=0 stays in IDLE.
- SCAN: each cycle tests the bit at ptr against the match polarity (value[ptr] XOR match_zero).
  - Match: idx<=ptr, idx_valid<=1, count+=1, go to EMIT.
  - No match at the last position: go to DONE.
  - No match otherwise: step ptr (+1, or -1 when msb_first), stay in SCAN.
- EMIT: idx and idx_valid hold stable until idx_ready=1 (valid/ready; the consumer may stall indefinitely).
  - On the accept edge idx_valid<=0.
  - If ptr is the last position, go to DONE; otherwise step ptr and go to SCAN.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE. In IDLE, busy=0 and done=0.
- Latency, with start accepted at edge E0, n matches, idx_ready tied high:
  - done is high during the cycle after edge E0+WIDTH+n.
  - busy falls one edge later.
  - First-position match: idx_valid is high in the cycle after E1.
- start outside IDLE is ignored; no queuing. Changes on value or the mode inputs during a scan have no effect.
- idx_ready while idx_valid=0 is ignored.
- Boundaries:
  - All-zero mask with match_zero=0: no idx_valid, count=0, done after WIDTH scan cycles.
  - All-ones mask: WIDTH emits, count=WIDTH, which needs IW+1 bits.
  - The last position is never stepped past; ptr does not wrap.
- start may be asserted in the cycle done is high; it is not sampled until IDLE, one cycle later.

Decomposition:
- Shared package ez8_pkg:
  - state encoding constants for the FSM (S_IDLE, S_SCAN, S_EMIT, S_DONE), 2-bit;
  - default WIDTH constant for the core byte size.
- No sub-module; ptr stepping and the match test are a few lines inline.

Test Plan:
- value=8'h00, match_zero=0, idx_ready=1 -> no idx_valid; done high in the cycle after E8; count=0; busy low after E9.
- value=8'hA5, lsb-first, idx_ready=1 -> idx sequence 0,2,5,7; count=4; done in the cycle after E12.
- value=8'hA5, msb_first=1 -> idx 7,5,2,0. Same value with match_zero=1, lsb-first -> idx 1,3,4,6; count=4.
- value=8'h81, idx_ready held low 5 cycles on the first emit -> idx=0 stays valid and stable for all 5 cycles; one accept only; next idx=7; count=2.
- start pulsed again mid-scan with value=8'hFF -> ignored; the original scan completes with its own count. Reset asserted while in EMIT -> the next cycle shows idx_valid=0, busy=0, count=0.
- value=8'hFF -> 8 emits, idx 0..7, count=8 (4'b1000). start asserted during the done cycle is not taken; the same start held one more cycle starts a new scan.

Source files
------------

// File: rtl/ez8_pkg.sv
// ez8 shared definitions: core byte width
// and the bit_scanner FSM state encoding.
package ez8_pkg;

  localparam int WIDTH_DEF = 8;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_SCAN = 2'd1;
  localparam state_t S_EMIT = 2'd2;
  localparam state_t S_DONE = 2'd3;

endpackage

// File: rtl/bit_scanner.sv
// Sequential mask decoder: walks a captured mask one bit per clock
// and hands out each matching position over valid/ready.
module bit_scanner
  import ez8_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  localparam int IW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [WIDTH-1:0] value,
  input  logic          msb_first,
  input  logic          match_zero,
  output logic          idx_valid,
  output logic [IW-1:0] idx,
  input  logic          idx_ready,
  output logic          busy,
  output logic          done,
  output logic [IW:0]   count
);

  localparam logic [IW-1:0] LAST_POS = IW'(WIDTH - 1);
  localparam logic [IW-1:0] PTR_ONE  = IW'(1);
  localparam logic [IW:0]   CNT_ONE  = (IW + 1)'(1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] val_q;
  logic             msb_q;
  logic             mz_q;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    ptr_nx;
  logic             hit;
  logic             last;

  assign hit    = val_q[ptr_q] ^ mz_q;
  assign last   = msb_q ? (ptr_q == '0) : (ptr_q == LAST_POS);
  assign ptr_nx = msb_q ? (ptr_q - PTR_ONE) : (ptr_q + PTR_ONE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: scan until a match or the last position, park in EMIT
  // until the consumer takes the index.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_SCAN;
      S_SCAN: begin
        if (hit)       state_d = S_EMIT;
        else if (last) state_d = S_DONE;
      end
      S_EMIT: begin
        if (idx_ready) state_d = last ? S_DONE : S_SCAN;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered status outputs, derived from where the FSM is heading.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_d != S_IDLE);
      done <= (state_d == S_DONE);
    end
  end

  // Job capture, pointer walk, match emission and counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      val_q     <= '0;
      msb_q     <= 1'b0;
      mz_q      <= 1'b0;
      ptr_q     <= '0;
      idx       <= '0;
      idx_valid <= 1'b0;
      count     <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            val_q <= value;
            msb_q <= msb_first;
            mz_q  <= match_zero;
            ptr_q <= msb_first ? LAST_POS : '0;
            count <= '0;
          end
        end
        S_SCAN: begin
          if (hit) begin
            idx       <= ptr_q;
            idx_valid <= 1'b1;
            count     <= count + CNT_ONE;
          end else if (!last) begin
            ptr_q <= ptr_nx;
          end
        end
        S_EMIT: begin
          if (idx_ready) begin
            idx_valid <= 1'b0;
            if (!last) ptr_q <= ptr_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_scanner.sv
// Directed bench for bit_scanner: a list-level model predicts every
// emitted position, the count and the done edge of each scan.
module tb_bit_scanner;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] value;
  logic         msb_first;
  logic         match_zero;
  logic         idx_valid;
  logic [2:0]   idx;
  logic         idx_ready;
  logic         busy;
  logic         done;
  logic [3:0]   count;

  int errors = 0;
  int checks = 0;

  int acc_q[$];
  logic       hold_q = 1'b0;
  logic [2:0] idx_hold = '0;

  bit_scanner dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .value(value),
    .msb_first(msb_first),
    .match_zero(match_zero),
    .idx_valid(idx_valid),
    .idx(idx),
    .idx_ready(idx_ready),
    .busy(busy),
    .done(done),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Matching positions in visiting order, straight from the mask.
  function automatic void model(input logic [W-1:0] v, input logic msb,
                                input logic mz, output int q[$]);
    int pos;
    q = {};
    for (int i = 0; i < W; i++) begin
      pos = msb ? (W - 1 - i) : i;
      if (v[pos] != mz) q.push_back(pos);
    end
  endfunction

  // Handshake edges: record every accepted index.
  always @(posedge clk) begin
    if (!reset && idx_valid && idx_ready) acc_q.push_back(int'(idx));
    hold_q   <= idx_valid && !idx_ready && !reset;
    idx_hold <= idx;
  end

  // Per-cycle protocol checks.
  always @(negedge clk) begin
    if (hold_q) begin
      chk("hold_valid", int'(idx_valid), 1);
      chk("hold_idx", int'(idx), int'(idx_hold));
    end
    if (done) chk("done_busy", int'(busy), 1);
    if (idx_valid) chk("valid_busy", int'(busy), 1);
  end

  task automatic launch(input logic [W-1:0] v, input logic msb,
                        input logic mz, input int stall);
    @(negedge clk);
    start      = 1'b1;
    value      = v;
    msb_first  = msb;
    match_zero = mz;
    idx_ready  = (stall == 0);
    acc_q      = {};
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic collect(input logic [W-1:0] v, input logic msb,
                         input logic mz, input int stall, input bit mid,
                         input bit chain, input logic [31:0] lit,
                         input int lit_n);
    int exp_q[$];
    int n;
    int stall_left;
    int done_k;
    int extra;
    model(v, msb, mz, exp_q);
    n = exp_q.size();
    chk("model_n", n, lit_n);
    for (int i = 0; i < lit_n && i < n; i++)
      chk("model_idx", exp_q[i], int'(lit[4*i +: 4]));
    stall_left = stall;
    done_k = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (mid && k == 3) begin
        start = 1'b1;
        value = 8'hFF;
      end
      if (mid && k == 4) begin
        start = 1'b0;
        value = v;
      end
      if (idx_valid && stall_left > 0) begin
        chk("stall_idx", int'(idx), exp_q[0]);
        stall_left--;
        if (stall_left == 0) idx_ready = 1'b1;
      end
      if (done) begin
        done_k = k;
        break;
      end
    end
    extra = (stall > 0) ? stall - 1 : 0;
    chk("done_edge", done_k, W + n + extra);
    chk("count", int'(count), n);
    chk("accepts", acc_q.size(), n);
    for (int i = 0; i < n && i < acc_q.size(); i++)
      chk("idx_seq", acc_q[i], exp_q[i]);
    if (chain) begin
      start      = 1'b1;
      value      = 8'h01;
      msb_first  = 1'b0;
      match_zero = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("busy_fall", int'(busy), 0);
    chk("done_fall", int'(done), 0);
    idx_ready = 1'b1;
  endtask

  task automatic scan(input logic [W-1:0] v, input logic msb,
                      input logic mz, input int stall, input bit mid,
                      input logic [31:0] lit, input int lit_n);
    launch(v, msb, mz, stall);
    collect(v, msb, mz, stall, mid, 1'b0, lit, lit_n);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    value      = '0;
    msb_first  = 1'b0;
    match_zero = 1'b0;
    idx_ready  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(idx_valid), 0);
    chk("rst_idx", int'(idx), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_count", int'(count), 0);
    reset = 1'b0;
    @(negedge clk);

    scan(8'h00, 1'b0, 1'b0, 0, 1'b0, 32'h0, 0);
    scan(8'hA5, 1'b0, 1'b0, 0, 1'b0, 32'h7520, 4);
    scan(8'hA5, 1'b1, 1'b0, 0, 1'b0, 32'h0257, 4);
    scan(8'hA5, 1'b0, 1'b1, 0, 1'b0, 32'h6431, 4);
    scan(8'h00, 1'b1, 1'b1, 0, 1'b0, 32'h01234567, 8);
    scan(8'h81, 1'b0, 1'b0, 6, 1'b0, 32'h70, 2);
    scan(8'h81, 1'b0, 1'b0, 0, 1'b1, 32'h70, 2);

    launch(8'hA5, 1'b0, 1'b0, 0);
    for (int k = 0; k < 20 && !idx_valid; k++) @(negedge clk);
    chk("pre_rst_valid", int'(idx_valid), 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_valid", int'(idx_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_count", int'(count), 0);
    reset = 1'b0;
    @(negedge clk);

    launch(8'hFF, 1'b0, 1'b0, 0);
    collect(8'hFF, 1'b0, 1'b0, 0, 1'b0, 1'b1, 32'h76543210, 8);
    chk("ff_count_bits", int'(count), 4'b1000);
    acc_q = {};
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("restart_busy", int'(busy), 1);
    collect(8'h01, 1'b0, 1'b0, 0, 1'b0, 1'b0, 32'h0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
